// File: rtl/sqdiff_arbiter_if.sv
// Bus bundle between the requesting stages, the arbiter and the shared sqdiff datapath.
// The arbiter takes the slave view; requesters plus datapath take the master view.
interface sqdiff_arbiter_if #(
  parameter int N  = 4,
  parameter int W  = 6,
  parameter int RW = 13
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]          req_valid;
  logic [N*W-1:0]        req_a;
  logic [N*W-1:0]        req_b;
  logic [N*W-1:0]        req_c;
  logic [N-1:0]          req_ready;
  logic [W-1:0]          dp_a;
  logic [W-1:0]          dp_b;
  logic [W-1:0]          dp_c;
  logic                  dp_issue;
  logic signed [RW-1:0]  dp_result;
  logic                  resp_valid;
  logic [IDW-1:0]        resp_id;
  logic signed [RW-1:0]  resp_result;

  modport slave (
    input  req_valid, req_a, req_b, req_c, dp_result,
    output req_ready, dp_a, dp_b, dp_c, dp_issue, resp_valid, resp_id, resp_result
  );

  modport master (
    output req_valid, req_a, req_b, req_c, dp_result,
    input  req_ready, dp_a, dp_b, dp_c, dp_issue, resp_valid, resp_id, resp_result
  );
endinterface

// File: rtl/sqdiff_arbiter.sv
// Round-robin scheduler sharing one pipelined squared-difference datapath among N requesters;
// a tag pipeline matched to the datapath latency routes each result back to its issuer.
module sqdiff_arbiter #(
  parameter int N   = 4,
  parameter int W   = 6,
  parameter int RW  = 13,
  parameter int LAT = 2
) (
  input logic           clk,
  input logic           rst,
  sqdiff_arbiter_if.slave bus
);
  localparam int IDW = $clog2(N);
  localparam logic [IDW:0] NV = (IDW+1)'(N);

  logic [IDW-1:0]            ptr;
  logic                      grant;
  logic [IDW-1:0]            gid;
  logic [IDW-1:0]            off;
  logic [2*N-1:0]            dbl;
  logic [IDW:0]              sum;
  logic [LAT-1:0]            tv;
  logic [LAT-1:0][IDW-1:0]   tid;

  // Rotating a doubled request vector puts the search start at bit 0; the lowest set
  // bit is the offset from ptr, mapped back to a requester index mod N.
  always_comb begin
    dbl   = {bus.req_valid, bus.req_valid} >> ptr;
    grant = 1'b0;
    off   = '0;
    for (int unsigned k = N; k > 0; k--) begin
      if (dbl[k-1]) begin
        grant = 1'b1;
        off   = IDW'(k - 1);
      end
    end
    grant = grant & rst;
    sum   = {1'b0, ptr} + {1'b0, off};
    gid   = (sum >= NV) ? IDW'(sum - NV) : IDW'(sum);
  end

  always_comb begin
    bus.req_ready = '0;
    bus.dp_a      = '0;
    bus.dp_b      = '0;
    bus.dp_c      = '0;
    bus.dp_issue  = grant;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant && gid == IDW'(i)) begin
        bus.req_ready[i] = 1'b1;
        bus.dp_a         = bus.req_a[i*W +: W];
        bus.dp_b         = bus.req_b[i*W +: W];
        bus.dp_c         = bus.req_c[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
      tv  <= '0;
      tid <= '0;
    end else begin
      if (grant) begin
        ptr <= (gid == IDW'(N - 1)) ? '0 : gid + 1'b1;
      end
      tv[0]  <= grant;
      tid[0] <= gid;
      for (int unsigned s = 1; s < LAT; s++) begin
        tv[s]  <= tv[s-1];
        tid[s] <= tid[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.resp_valid  <= 1'b0;
      bus.resp_id     <= '0;
      bus.resp_result <= '0;
    end else begin
      bus.resp_valid <= tv[LAT-1];
      if (tv[LAT-1]) begin
        bus.resp_id     <= tid[LAT-1];
        bus.resp_result <= bus.dp_result;
      end
    end
  end
endmodule

// File: tb/tb_sqdiff_arbiter.sv
// Bench for sqdiff_arbiter: hand-computed vector table for the directed corners, then
// randomized traffic against a queue-based reference model; the datapath is a LAT-deep stub.
module tb_sqdiff_arbiter;
  localparam int N = 4, W = 6, RW = 13, LAT = 2;

  logic clk = 1'b0;
  logic rst;
  int   mode = 0;
  int   cyc  = 0;
  int   nvec = 0;
  int   nerr = 0;

  sqdiff_arbiter_if #(.N(N), .W(W), .RW(RW)) bus ();

  sqdiff_arbiter #(.N(N), .W(W), .RW(RW), .LAT(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // mode 0: a+b+c, mode 1: a+b+c-200 (mostly negative), mode 2: constant -1
  function automatic logic [RW-1:0] stub_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] c, input int md);
    int s;
    s = int'(a) + int'(b) + int'(c);
    if (md == 1) s = s - 200;
    else if (md == 2) s = -1;
    return RW'(s);
  endfunction

  logic [RW-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= stub_f(bus.dp_a, bus.dp_b, bus.dp_c, mode);
    for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
  end
  assign bus.dp_result = pipe[LAT-1];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic          rst;
    logic [N-1:0]  valid;
    logic [W-1:0]  a, b, c;
    int            mode;
    logic [N-1:0]  rdy;
    logic          rv;
    logic [1:0]    rid;
    logic [RW-1:0] res;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [N-1:0] v, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] c, input int md,
                              input logic [N-1:0] rdy, input logic rv, input logic [1:0] rid,
                              input logic [RW-1:0] res);
    vec_t t;
    t.rst = r; t.valid = v; t.a = a; t.b = b; t.c = c; t.mode = md;
    t.rdy = rdy; t.rv = rv; t.rid = rid; t.res = res;
    return t;
  endfunction

  localparam int NT = 38;
  vec_t tab [NT];

  typedef struct {
    int            id;
    logic [RW-1:0] res;
    int            due;
  } rsp_t;
  rsp_t q [$];

  logic [N-1:0] pend;
  logic [W-1:0] la [N];
  logic [W-1:0] lb [N];
  logic [W-1:0] lc [N];
  int           mptr;
  int           lid;
  logic [RW-1:0] lres;

  initial begin
    rst = 1'b0;
    bus.req_valid = '0;
    bus.req_a = '0; bus.req_b = '0; bus.req_c = '0;

    // reset hold, then round-robin over four continuously-valid requesters
    tab[0]  = mk(0, 4'b1111,  1,  1,  1, 0, 4'b0000, 0, 0, 13'd0);
    tab[1]  = mk(0, 4'b1111,  1,  1,  1, 0, 4'b0000, 0, 0, 13'd0);
    tab[2]  = mk(1, 4'b1111,  1,  2,  3, 0, 4'b0001, 0, 0, 13'd0);
    tab[3]  = mk(1, 4'b1111,  1,  2,  3, 0, 4'b0010, 0, 0, 13'd0);
    tab[4]  = mk(1, 4'b1111,  1,  2,  3, 0, 4'b0100, 0, 0, 13'd0);
    tab[5]  = mk(1, 4'b1111,  1,  2,  3, 0, 4'b1000, 1, 0, 13'd6);
    tab[6]  = mk(1, 4'b1111,  1,  2,  3, 0, 4'b0001, 1, 1, 13'd6);
    tab[7]  = mk(1, 4'b0000,  0,  0,  0, 0, 4'b0000, 1, 2, 13'd6);
    tab[8]  = mk(1, 4'b0000,  0,  0,  0, 0, 4'b0000, 1, 3, 13'd6);
    tab[9]  = mk(1, 4'b0000,  0,  0,  0, 0, 4'b0000, 1, 0, 13'd6);
    tab[10] = mk(1, 4'b0000,  0,  0,  0, 0, 4'b0000, 0, 0, 13'd6);
    // single request from requester 2
    tab[11] = mk(1, 4'b0100,  4,  8,  2, 0, 4'b0100, 0, 0, 13'd6);
    tab[12] = mk(1, 4'b0000,  0,  0,  0, 0, 4'b0000, 0, 0, 13'd6);
    tab[13] = mk(1, 4'b0000,  0,  0,  0, 0, 4'b0000, 0, 0, 13'd6);
    tab[14] = mk(1, 4'b0000,  0,  0,  0, 0, 4'b0000, 1, 2, 13'd14);
    // ptr=3, requesters 1 and 3: wrap then skip; requester 1 alone every cycle
    tab[15] = mk(1, 4'b1010,  5,  5,  5, 0, 4'b1000, 0, 2, 13'd14);
    tab[16] = mk(1, 4'b0010,  5,  5,  5, 0, 4'b0010, 0, 2, 13'd14);
    tab[17] = mk(1, 4'b0010,  5,  5,  5, 0, 4'b0010, 0, 2, 13'd14);
    tab[18] = mk(1, 4'b0010,  5,  5,  5, 0, 4'b0010, 1, 3, 13'd15);
    tab[19] = mk(1, 4'b0000,  0,  0,  0, 0, 4'b0000, 1, 1, 13'd15);
    tab[20] = mk(1, 4'b0000,  0,  0,  0, 0, 4'b0000, 1, 1, 13'd15);
    tab[21] = mk(1, 4'b0000,  0,  0,  0, 0, 4'b0000, 1, 1, 13'd15);
    tab[22] = mk(1, 4'b0000,  0,  0,  0, 0, 4'b0000, 0, 1, 13'd15);
    // maximum operands and a -1 result
    tab[23] = mk(1, 4'b0001, 63, 63, 63, 0, 4'b0001, 0, 1, 13'd15);
    tab[24] = mk(1, 4'b0010,  0,  0,  0, 2, 4'b0010, 0, 1, 13'd15);
    tab[25] = mk(1, 4'b0000,  0,  0,  0, 0, 4'b0000, 0, 1, 13'd15);
    tab[26] = mk(1, 4'b0000,  0,  0,  0, 0, 4'b0000, 1, 0, 13'd189);
    tab[27] = mk(1, 4'b0000,  0,  0,  0, 0, 4'b0000, 1, 1, 13'h1FFF);
    tab[28] = mk(1, 4'b0000,  0,  0,  0, 0, 4'b0000, 0, 1, 13'h1FFF);
    // two ops in flight, reset before either retires
    tab[29] = mk(1, 4'b0011,  1,  1,  1, 0, 4'b0001, 0, 1, 13'h1FFF);
    tab[30] = mk(1, 4'b0010,  1,  1,  1, 0, 4'b0010, 0, 1, 13'h1FFF);
    tab[31] = mk(0, 4'b0000,  0,  0,  0, 0, 4'b0000, 0, 0, 13'd0);
    tab[32] = mk(1, 4'b0000,  0,  0,  0, 0, 4'b0000, 0, 0, 13'd0);
    tab[33] = mk(1, 4'b0000,  0,  0,  0, 0, 4'b0000, 0, 0, 13'd0);
    tab[34] = mk(1, 4'b1111,  7,  9, 11, 0, 4'b0001, 0, 0, 13'd0);
    tab[35] = mk(1, 4'b0000,  0,  0,  0, 0, 4'b0000, 0, 0, 13'd0);
    tab[36] = mk(1, 4'b0000,  0,  0,  0, 0, 4'b0000, 0, 0, 13'd0);
    tab[37] = mk(1, 4'b0000,  0,  0,  0, 0, 4'b0000, 1, 0, 13'd27);

    for (int r = 0; r < NT; r++) begin
      @(negedge clk);
      cyc++;
      rst  = tab[r].rst;
      mode = tab[r].mode;
      bus.req_valid = tab[r].valid;
      bus.req_a = {N{tab[r].a}};
      bus.req_b = {N{tab[r].b}};
      bus.req_c = {N{tab[r].c}};
      #1;
      check("t_ready", 32'(bus.req_ready), 32'(tab[r].rdy));
      check("t_issue", 32'(bus.dp_issue), 32'(|tab[r].rdy));
      check("t_dp_a", 32'(bus.dp_a), (tab[r].rdy != '0) ? 32'(tab[r].a) : 32'd0);
      check("t_resp_valid", 32'(bus.resp_valid), 32'(tab[r].rv));
      check("t_resp_id", 32'(bus.resp_id), 32'(tab[r].rid));
      check("t_resp_result", 32'($unsigned(bus.resp_result)), 32'(tab[r].res));
    end

    pend = '0;
    mptr = 0; lid = 0; lres = '0;
    for (int i = 0; i < N; i++) begin la[i] = '0; lb[i] = '0; lc[i] = '0; end

    for (int k = 0; k < 450; k++) begin
      int dens;
      int g;
      logic [N-1:0] erdy;
      logic         erv;
      dens = (k < 150) ? 90 : (k < 300) ? 30 : 60;
      @(negedge clk);
      cyc++;
      rst  = (k == 0 || $urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
      mode = int'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          pend[i] = ($urandom_range(0, 99) < dens);
          la[i] = ($urandom_range(0, 3) == 0) ? 6'd63 : W'($urandom_range(0, 63));
          lb[i] = ($urandom_range(0, 3) == 0) ? 6'd63 : W'($urandom_range(0, 63));
          lc[i] = ($urandom_range(0, 3) == 0) ? 6'd0  : W'($urandom_range(0, 63));
        end
        bus.req_a[i*W +: W] = la[i];
        bus.req_b[i*W +: W] = lb[i];
        bus.req_c[i*W +: W] = lc[i];
      end
      bus.req_valid = pend;
      #1;
      if (!rst) begin
        q.delete();
        mptr = 0; lid = 0; lres = '0;
      end
      g = -1;
      if (rst) begin
        for (int j = 0; j < N; j++) begin
          if (g < 0 && pend[(mptr + j) % N]) g = (mptr + j) % N;
        end
      end
      erdy = (g >= 0) ? N'(1 << g) : '0;
      check("r_ready", 32'(bus.req_ready), 32'(erdy));
      check("r_issue", 32'(bus.dp_issue), (g >= 0) ? 32'd1 : 32'd0);
      check("r_dp_a", 32'(bus.dp_a), (g >= 0) ? 32'(la[g]) : 32'd0);
      check("r_dp_b", 32'(bus.dp_b), (g >= 0) ? 32'(lb[g]) : 32'd0);
      check("r_dp_c", 32'(bus.dp_c), (g >= 0) ? 32'(lc[g]) : 32'd0);
      erv = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        erv  = 1'b1;
        lid  = q[0].id;
        lres = q[0].res;
        void'(q.pop_front());
      end
      check("r_resp_valid", 32'(bus.resp_valid), 32'(erv));
      check("r_resp_id", 32'(bus.resp_id), 32'(lid));
      check("r_resp_result", 32'($unsigned(bus.resp_result)), 32'(lres));
      if (g >= 0) begin
        q.push_back(rsp_t'{g, stub_f(la[g], lb[g], lc[g], mode), cyc + LAT + 1});
        mptr = (g + 1) % N;
        pend[g] = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
